// File: rtl/rv_pkg.sv
// Shared RISC-V front-end constants: datapath widths, reset vector
// and the fetch FSM state encoding.
package rv_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int FETCH_QDEPTH = 2;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_BUSY = 2'd1;
  localparam fetch_state_t ST_DISCARD = 2'd2;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries between memory and decode.
// Flush overrides push and pop; head outputs come straight from storage.
module fetch_queue #(
  parameter int W = 64,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output logic [W-1:0]  head_data
);

  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_valid = (count != '0);
  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one-outstanding word reads
// to the ROM and feeds {pc, instr} to decode through a prefetch queue.
module instr_fetch_unit #(
  parameter int WORD_SIZE = rv_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH = rv_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC =
    ADDR_WIDTH'(rv_pkg::RESET_PC),
  parameter int QDEPTH = rv_pkg::FETCH_QDEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [WORD_SIZE-1:0]  if_instr
);

  import rv_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = ADDR_WIDTH + WORD_SIZE;

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] pc_nxt;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] redir;
  logic [AW-3:0] addr_nxt;
  logic          req_nxt;

  logic [CW-1:0] count;
  logic [CW:0]   level;
  logic          ack;
  logic          push;
  logic          pop;
  logic          room;
  logic          st_idle;
  logic          st_busy;
  logic [EW-1:0] head;

  assign st_idle = (state == ST_IDLE);
  assign st_busy = (state == ST_BUSY);

  // Acks only count against a live request.
  assign ack = mem_req & mem_ack;
  assign pop = if_valid & if_ready;
  assign push = st_busy & ack & ~redirect_valid;

  assign pc_inc = fetch_pc + AW'(4);
  assign redir = redirect_pc & ~AW'(3);

  // Occupancy after this cycle; no request is in flight when it is used.
  assign level = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign room = level < (CW+1)'(QDEPTH);

  always_comb begin
    state_nxt = state;
    req_nxt = mem_req;
    addr_nxt = mem_addr;
    pc_nxt = fetch_pc;
    if (redirect_valid) begin
      pc_nxt = redir;
      if (!st_idle && !ack) begin
        state_nxt = ST_DISCARD;
      end else begin
        state_nxt = ST_BUSY;
        req_nxt = 1'b1;
        addr_nxt = redir[AW-1:2];
      end
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (room) begin
            state_nxt = ST_BUSY;
            req_nxt = 1'b1;
            addr_nxt = fetch_pc[AW-1:2];
          end
        end
        st_busy: begin
          if (ack) begin
            pc_nxt = pc_inc;
            if (room) begin
              addr_nxt = pc_inc[AW-1:2];
            end else begin
              state_nxt = ST_IDLE;
              req_nxt = 1'b0;
            end
          end
        end
        default: begin
          if (ack) begin
            state_nxt = ST_BUSY;
            req_nxt = 1'b1;
            addr_nxt = fetch_pc[AW-1:2];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      mem_req <= 1'b0;
      mem_addr <= '0;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      mem_req <= req_nxt;
      mem_addr <= addr_nxt;
      fetch_pc <= pc_nxt;
    end
  end

  fetch_queue #(
    .W(EW),
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .push_data({fetch_pc, mem_rdata}),
    .pop(pop),
    .flush(redirect_valid),
    .count(count),
    .head_valid(if_valid),
    .head_data(head)
  );

  assign if_pc = head[EW-1:WORD_SIZE];
  assign if_instr = head[WORD_SIZE-1:0];

endmodule
